// File: rtl/ps2m_seq.sv
// PS/2 mouse initialisation script sequencer and movement-packet framer.
// Define PS2M_WHEEL_EN to add the IntelliMouse unlock sequence, 4-byte packets and pkt_dz.
`timescale 1ns/1ps
module ps2m_seq #(
    parameter int unsigned clk_freq        = 50_000_000,
    parameter int unsigned resp_timeout_ms = 500,
    parameter int unsigned gap_timeout_us  = 2000,
    parameter logic [7:0]  sample_rate     = 8'd100,
    parameter int unsigned max_retries     = 4
) (
    input  logic       clock,
    input  logic       reset,
    output logic       tx_ena,
    output logic [8:0] tx_cmd,
    input  logic       tx_busy,
    input  logic [7:0] rx_code,
    input  logic       rx_new,
    output logic       ready,
    output logic       error,
    output logic [3:0] retry_cnt,
    output logic       packet_valid,
    output logic [7:0] pkt_flags,
    output logic [7:0] pkt_dx,
`ifdef PS2M_WHEEL_EN
    output logic [7:0] pkt_dz,
`endif
    output logic [7:0] pkt_dy
);

    localparam longint unsigned RESP_RAW = (64'(clk_freq) * 64'(resp_timeout_ms)) / 64'd1000;
    localparam longint unsigned GAP_RAW  = (64'(clk_freq) * 64'(gap_timeout_us)) / 64'd1000000;
    localparam longint unsigned RESP_CYC = (RESP_RAW < 64'd1) ? 64'd1 : RESP_RAW;
    localparam longint unsigned GAP_CYC  = (GAP_RAW < 64'd1) ? 64'd1 : GAP_RAW;
    localparam int RESP_W = $clog2(RESP_CYC + 64'd1);
    localparam int GAP_W  = $clog2(GAP_CYC + 64'd1);
    localparam logic [RESP_W-1:0] RESP_TERM = RESP_W'(RESP_CYC - 64'd1);
    localparam logic [GAP_W-1:0]  GAP_TERM  = GAP_W'(GAP_CYC - 64'd1);

`ifdef PS2M_WHEEL_EN
    localparam logic [3:0] LAST_PTR = 4'd10;
    localparam logic [3:0] ID_PTR   = 4'd9;
`else
    localparam logic [3:0] LAST_PTR = 4'd3;
`endif

    typedef enum logic [2:0] {
        S_TX,
        S_RX,
        S_RETRY,
        S_FAIL,
        S_STREAM
    } state_t;

    state_t            state_reg;
    logic [3:0]        ptr_reg;
    logic [1:0]        ridx_reg;
    logic              resend_used_reg;
    logic [RESP_W-1:0] resp_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [1:0]        sidx_reg;
    logic [7:0]        sh_flags_reg;
    logic [7:0]        sh_dx_reg;
    logic              rx_prev_reg;
    logic              tx_ena_reg;
    logic [8:0]        tx_cmd_reg;
    logic              ready_reg;
    logic              error_reg;
    logic [3:0]        retry_reg;
    logic              pv_reg;
    logic [7:0]        flags_reg;
    logic [7:0]        dx_reg;
    logic [7:0]        dy_reg;
`ifdef PS2M_WHEEL_EN
    logic              wheel_reg;
    logic [7:0]        sh_dy_reg;
    logic [7:0]        dz_reg;
    assign pkt_dz = dz_reg;
`endif

    logic strobe;
    assign strobe = rx_new & ~rx_prev_reg;

    assign tx_ena       = tx_ena_reg;
    assign tx_cmd       = tx_cmd_reg;
    assign ready        = ready_reg;
    assign error        = error_reg;
    assign retry_cnt    = retry_reg;
    assign packet_valid = pv_reg;
    assign pkt_flags    = flags_reg;
    assign pkt_dx       = dx_reg;
    assign pkt_dy       = dy_reg;

    function automatic logic [7:0] step_cmd(input logic [3:0] p);
        logic [7:0] c;
        c = 8'hF4;
`ifdef PS2M_WHEEL_EN
        case (p)
            4'd0:                      c = 8'hFF;
            4'd1, 4'd3, 4'd5, 4'd7:    c = 8'hF3;
            4'd2:                      c = sample_rate;
            4'd4:                      c = 8'hC8;
            4'd6:                      c = 8'h64;
            4'd8:                      c = 8'h50;
            4'd9:                      c = 8'hF2;
            default:                   c = 8'hF4;
        endcase
`else
        case (p)
            4'd0:    c = 8'hFF;
            4'd1:    c = 8'hF3;
            4'd2:    c = sample_rate;
            default: c = 8'hF4;
        endcase
`endif
        return c;
    endfunction

    // Odd parity in bit 8: the transceiver sends these nine bits as-is.
    function automatic logic [8:0] frame(input logic [7:0] b);
        return {~(^b), b};
    endfunction

    function automatic logic resp_ok(input logic [3:0] p, input logic [1:0] idx, input logic [7:0] code);
        logic ok;
        ok = 1'b0;
        if (idx == 2'd0)
            ok = (code == 8'hFA);
        else if (p == 4'd0)
            ok = (idx == 2'd1) ? (code == 8'hAA) : (code == 8'h00);
`ifdef PS2M_WHEEL_EN
        else if (p == ID_PTR)
            ok = (code == 8'h00) || (code == 8'h03);
`endif
        return ok;
    endfunction

    function automatic logic resp_last(input logic [3:0] p, input logic [1:0] idx);
        logic last;
        last = (idx == 2'd0);
        if (p == 4'd0)
            last = (idx == 2'd2);
`ifdef PS2M_WHEEL_EN
        else if (p == ID_PTR)
            last = (idx == 2'd1);
`endif
        return last;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg       <= S_TX;
            ptr_reg         <= '0;
            ridx_reg        <= '0;
            resend_used_reg <= 1'b0;
            resp_cnt_reg    <= '0;
            gap_cnt_reg     <= '0;
            sidx_reg        <= '0;
            sh_flags_reg    <= '0;
            sh_dx_reg       <= '0;
            rx_prev_reg     <= 1'b0;
            tx_ena_reg      <= 1'b0;
            tx_cmd_reg      <= '0;
            ready_reg       <= 1'b0;
            error_reg       <= 1'b0;
            retry_reg       <= '0;
            pv_reg          <= 1'b0;
            flags_reg       <= '0;
            dx_reg          <= '0;
            dy_reg          <= '0;
`ifdef PS2M_WHEEL_EN
            wheel_reg       <= 1'b0;
            sh_dy_reg       <= '0;
            dz_reg          <= '0;
`endif
        end else begin
            rx_prev_reg <= rx_new;
            pv_reg      <= 1'b0;
            case (state_reg)
                S_TX: begin
                    tx_ena_reg   <= 1'b1;
                    tx_cmd_reg   <= frame(step_cmd(ptr_reg));
                    resp_cnt_reg <= '0;
                    ridx_reg     <= '0;
                    // Only a busy seen while our request is up counts as acceptance.
                    if (tx_ena_reg && tx_busy) begin
                        tx_ena_reg <= 1'b0;
                        state_reg  <= S_RX;
                    end
                end
                S_RX: begin
                    tx_ena_reg <= 1'b0;
                    if (strobe) begin
                        resp_cnt_reg <= '0;
                        if (rx_code == 8'hFE && !resend_used_reg) begin
                            resend_used_reg <= 1'b1;
                            state_reg       <= S_TX;
                        end else if (resp_ok(ptr_reg, ridx_reg, rx_code)) begin
`ifdef PS2M_WHEEL_EN
                            if (ptr_reg == ID_PTR && ridx_reg == 2'd1)
                                wheel_reg <= (rx_code == 8'h03);
`endif
                            if (!resp_last(ptr_reg, ridx_reg)) begin
                                ridx_reg <= ridx_reg + 2'd1;
                            end else if (ptr_reg == LAST_PTR) begin
                                ready_reg   <= 1'b1;
                                sidx_reg    <= '0;
                                gap_cnt_reg <= '0;
                                state_reg   <= S_STREAM;
                            end else begin
                                ptr_reg         <= ptr_reg + 4'd1;
                                resend_used_reg <= 1'b0;
                                state_reg       <= S_TX;
                            end
                        end else begin
                            state_reg <= S_RETRY;
                        end
                    end else if (resp_cnt_reg == RESP_TERM) begin
                        state_reg <= S_RETRY;
                    end else begin
                        resp_cnt_reg <= resp_cnt_reg + 1'b1;
                    end
                end
                S_RETRY: begin
                    retry_reg <= retry_reg + 4'd1;
                    if (retry_reg + 4'd1 == 4'(max_retries)) begin
                        error_reg <= 1'b1;
                        state_reg <= S_FAIL;
                    end else begin
                        ptr_reg         <= '0;
                        resend_used_reg <= 1'b0;
                        state_reg       <= S_TX;
                    end
                end
                S_FAIL: begin
                    tx_ena_reg <= 1'b0;
                end
                S_STREAM: begin
                    if (strobe) begin
                        gap_cnt_reg <= '0;
                        case (sidx_reg)
                            2'd0: begin
                                // Bit 3 is always set in a real first byte; use it to resync.
                                if (rx_code[3]) begin
                                    sh_flags_reg <= rx_code;
                                    sidx_reg     <= 2'd1;
                                end
                            end
                            2'd1: begin
                                if (sh_flags_reg == 8'hAA && rx_code == 8'h00) begin
                                    ready_reg       <= 1'b0;
                                    retry_reg       <= '0;
                                    ptr_reg         <= '0;
                                    resend_used_reg <= 1'b0;
                                    sidx_reg        <= '0;
                                    state_reg       <= S_TX;
`ifdef PS2M_WHEEL_EN
                                    wheel_reg       <= 1'b0;
`endif
                                end else begin
                                    sh_dx_reg <= rx_code;
                                    sidx_reg  <= 2'd2;
                                end
                            end
                            2'd2: begin
`ifdef PS2M_WHEEL_EN
                                if (wheel_reg) begin
                                    sh_dy_reg <= rx_code;
                                    sidx_reg  <= 2'd3;
                                end else begin
                                    flags_reg <= sh_flags_reg;
                                    dx_reg    <= sh_dx_reg;
                                    dy_reg    <= rx_code;
                                    dz_reg    <= '0;
                                    pv_reg    <= 1'b1;
                                    sidx_reg  <= '0;
                                end
`else
                                flags_reg <= sh_flags_reg;
                                dx_reg    <= sh_dx_reg;
                                dy_reg    <= rx_code;
                                pv_reg    <= 1'b1;
                                sidx_reg  <= '0;
`endif
                            end
                            default: begin
`ifdef PS2M_WHEEL_EN
                                flags_reg <= sh_flags_reg;
                                dx_reg    <= sh_dx_reg;
                                dy_reg    <= sh_dy_reg;
                                dz_reg    <= rx_code;
                                pv_reg    <= 1'b1;
`endif
                                sidx_reg  <= '0;
                            end
                        endcase
                    end else if (sidx_reg != 2'd0) begin
                        if (gap_cnt_reg == GAP_TERM) begin
                            sidx_reg    <= '0;
                            gap_cnt_reg <= '0;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= S_FAIL;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2m_seq.sv
// Directed and randomized bench for ps2m_seq: plays a scripted mouse and checks packets against a queue model.
`timescale 1ns/1ps
module tb_ps2m_seq;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tx_ena;
    logic [8:0] tx_cmd;
    logic       tx_busy = 1'b0;
    logic [7:0] rx_code = 8'h00;
    logic       rx_new = 1'b0;
    logic       ready;
    logic       error;
    logic [3:0] retry_cnt;
    logic       packet_valid;
    logic [7:0] pkt_flags;
    logic [7:0] pkt_dx;
    logic [7:0] pkt_dy;

    int errors = 0;
    int checks = 0;

    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];
    logic [7:0]  script[4] = '{8'hFF, 8'hF3, 8'd100, 8'hF4};
    logic [7:0]  f, d, y, j;
    logic        seen;

    // 100 kHz nominal clock: response timeout = 100 cycles, packet gap = 20 cycles.
    ps2m_seq #(
        .clk_freq(100_000), .resp_timeout_ms(1), .gap_timeout_us(200),
        .sample_rate(8'd100), .max_retries(4)
    ) dut (
        .clock(clock), .reset(reset), .tx_ena(tx_ena), .tx_cmd(tx_cmd), .tx_busy(tx_busy),
        .rx_code(rx_code), .rx_new(rx_new), .ready(ready), .error(error), .retry_cnt(retry_cnt),
        .packet_valid(packet_valid), .pkt_flags(pkt_flags), .pkt_dx(pkt_dx), .pkt_dy(pkt_dy)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (packet_valid === 1'b1) got_q.push_back({pkt_flags, pkt_dx, pkt_dy});

    function automatic logic [8:0] frame(input logic [7:0] b);
        return {~(^b), b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_code = b;
        rx_new  = 1'b1;
        repeat (2) @(negedge clock);
        rx_new  = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // Play the transceiver: accept one request, report busy for a few cycles.
    task automatic expect_cmd(input string tag, input logic [7:0] b);
        logic [8:0] c;
        logic       ok;
        c  = '0;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            if (tx_ena === 1'b1) begin
                c  = tx_cmd;
                ok = 1'b1;
            end
        end
        if (ok) begin
            tx_busy = 1'b1;
            repeat (3) @(negedge clock);
            tx_busy = 1'b0;
        end
        check({tag, "_seen"}, 32'(ok), 32'd1);
        check(tag, 32'(c), 32'(frame(b)));
    endtask

    task automatic init_good();
        for (int i = 0; i < 4; i++) begin
            expect_cmd($sformatf("cmd%0d", i), script[i]);
            send_byte(8'hFA);
            if (i == 0) begin
                send_byte(8'hAA);
                send_byte(8'h00);
            end
        end
        repeat (3) @(negedge clock);
        check("ready_after_init", 32'(ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b0;
        tx_busy = 1'b0;
        rx_new  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic compare_packets(input string tag);
        repeat (5) @(negedge clock);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_pkt%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset values while reset is held low.
        repeat (3) @(negedge clock);
        check("rst_tx_ena", 32'(tx_ena), 32'd0);
        check("rst_tx_cmd", 32'(tx_cmd), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_retry", 32'(retry_cnt), 32'd0);
        check("rst_pv", 32'(packet_valid), 32'd0);
        check("rst_pkt", 32'({pkt_flags, pkt_dx, pkt_dy}), 32'd0);
        reset = 1'b1;

        // Normal init then directed stream traffic.
        init_good();
        check("init_retry", 32'(retry_cnt), 32'd0);
        got_q.delete();
        send_byte(8'h09); send_byte(8'h05); send_byte(8'hFB);
        exp_q.push_back(24'h0905FB);
        send_byte(8'h02);
        send_byte(8'h08); send_byte(8'h01); send_byte(8'h01);
        exp_q.push_back(24'h080101);
        compare_packets("direct");

        // Randomized packets with junk (bit3 clear) between them.
        for (int k = 0; k < 16; k++) begin
            f = 8'($urandom); f[3] = 1'b1;
            d = 8'($urandom);
            y = 8'($urandom);
            if (f == 8'hAA && d == 8'h00) d = 8'h01;
            if ($urandom_range(0, 2) == 0) begin
                j = 8'($urandom); j[3] = 1'b0;
                send_byte(j);
            end
            send_byte(f); send_byte(d); send_byte(y);
            exp_q.push_back({f, d, y});
        end
        compare_packets("random");

        // Inter-byte gap drops a partial packet.
        send_byte(8'h08); send_byte(8'h03);
        repeat (40) @(negedge clock);
        send_byte(8'h18); send_byte(8'hFF); send_byte(8'h00);
        exp_q.push_back(24'h18FF00);
        compare_packets("gap");

        // Bad BAT on first attempt, good second attempt.
        do_reset();
        expect_cmd("badbat_ff", 8'hFF);
        send_byte(8'hFA);
        send_byte(8'hFC);
        init_good();
        check("badbat_retry", 32'(retry_cnt), 32'd1);

        // Hot-plug BAT in stream mode restarts the script and clears retries.
        send_byte(8'hAA); send_byte(8'h00);
        repeat (2) @(negedge clock);
        check("hotplug_ready", 32'(ready), 32'd0);
        check("hotplug_retry", 32'(retry_cnt), 32'd0);
        init_good();

        // Resend request on F4 causes one retransmission without a retry.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            expect_cmd($sformatf("rs_cmd%0d", i), script[i]);
            send_byte(8'hFA);
            if (i == 0) begin
                send_byte(8'hAA);
                send_byte(8'h00);
            end
        end
        expect_cmd("rs_f4", 8'hF4);
        send_byte(8'hFE);
        expect_cmd("rs_f4_again", 8'hF4);
        check("rs_retry", 32'(retry_cnt), 32'd0);
        send_byte(8'hFA);
        repeat (3) @(negedge clock);
        check("rs_ready", 32'(ready), 32'd1);

        // Silent mouse: four timeouts, then sticky error and no more requests.
        do_reset();
        for (int i = 0; i < 4; i++) expect_cmd($sformatf("silent%0d", i), 8'hFF);
        seen = 1'b0;
        repeat (150) begin
            @(negedge clock);
            if (tx_ena !== 1'b0) seen = 1'b1;
        end
        check("silent_error", 32'(error), 32'd1);
        check("silent_retry", 32'(retry_cnt), 32'd4);
        check("silent_ready", 32'(ready), 32'd0);
        check("silent_no_tx", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
